// File: rtl/rf_writeback.sv
// ---------------------------------------------------------------------------
// rf_writeback
//
// Writeback stage in front of the single register-file write port.
//
// The stage merges two result sources into one registered write per cycle:
//   * the in-order pipeline (ALU / LSU). It cannot be stalled, so it always
//     wins the port when it has a real destination (rd != x0).
//   * a long-latency MUL/DIV unit. One of its results at a time is parked in
//     a skid register (hold_*). The skid register drains whenever the
//     pipeline leaves the port free.
// Load words from the LSU are aligned and sign/zero-extended here.
// A 32-bit busy scoreboard marks destinations that still wait on a MUL/DIV
// result. Decode uses it to stall on RAW/WAW hazards.
//
// Handshake (MUL/DIV side): a result moves into the skid register on every
// rising edge where md_valid && md_ready. md_ready depends only on the skid
// register's state and on reset. It never depends on md_valid, so the
// producer may raise md_valid in response to md_ready without building a
// combinational loop. md_valid may be dropped at any time.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   pl_valid/rd/data    pipeline result (ALU result or raw load word)
//   pl_load/funct3/
//   pl_byte_off         load alignment / extension controls
//   md_valid/rd/data    MUL/DIV result offer
//   md_ready            skid register is free
//   iss_valid/iss_rd    MUL/DIV issue, marks iss_rd busy
//   rd_we/addr/data     registered register-file write
//   busy                pending MUL/DIV destinations (bit 0 always 0)
// ---------------------------------------------------------------------------
module rf_writeback #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            pl_valid,
  input  logic [4:0]      pl_rd,
  input  logic [XLEN-1:0] pl_data,
  input  logic            pl_load,
  input  logic [2:0]      pl_funct3,
  input  logic [1:0]      pl_byte_off,

  input  logic            md_valid,
  input  logic [4:0]      md_rd,
  input  logic [XLEN-1:0] md_data,
  output logic            md_ready,

  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,

  output logic            rd_we,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,

  output logic [31:0]     busy
);

  // Load types encoded in funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic            hold_valid_q, hold_valid_d;
  logic [4:0]      hold_rd_q,    hold_rd_d;
  logic [XLEN-1:0] hold_data_q,  hold_data_d;

  logic            rd_we_q,      rd_we_d;
  logic [4:0]      rd_addr_q,    rd_addr_d;
  logic [XLEN-1:0] rd_data_q,    rd_data_d;

  logic [31:0]     busy_q,       busy_d;

  // -------------------------------------------------------------------------
  // Load alignment and extension
  // -------------------------------------------------------------------------
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] pl_wdata;

  always_comb begin
    ld_byte = 8'h00;
    case (pl_byte_off)
      2'd0:    ld_byte = pl_data[7:0];
      2'd1:    ld_byte = pl_data[15:8];
      2'd2:    ld_byte = pl_data[23:16];
      default: ld_byte = pl_data[31:24];
    endcase

    // Halfword loads pick a half by address bit 1. Address bit 0 is ignored,
    // so a misaligned halfword offset reads the enclosing aligned halfword.
    ld_half = pl_byte_off[1] ? pl_data[31:16] : pl_data[15:0];

    pl_wdata = pl_data;
    if (pl_load) begin
      case (pl_funct3)
        F3_LB:   pl_wdata = {{(XLEN-8){ld_byte[7]}}, ld_byte};
        F3_LH:   pl_wdata = {{(XLEN-16){ld_half[15]}}, ld_half};
        F3_LBU:  pl_wdata = {{(XLEN-8){1'b0}}, ld_byte};
        F3_LHU:  pl_wdata = {{(XLEN-16){1'b0}}, ld_half};
        default: pl_wdata = pl_data;  // LW and unused encodings
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Arbitration, skid register and scoreboard
  // -------------------------------------------------------------------------
  logic md_xfer;
  logic pl_owns_port;
  logic hold_drain;

  // Held low in reset so that nothing is accepted into a skid register that
  // is being cleared at the same edge.
  assign md_ready = !hold_valid_q && !reset;
  assign md_xfer  = md_valid && md_ready;

  // A pipeline result aimed at x0 is architecturally a no-op. It does not
  // take the port, so the skid register can drain in that cycle.
  assign pl_owns_port = pl_valid && (pl_rd != 5'd0);
  assign hold_drain   = hold_valid_q && !pl_owns_port;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_rd_d    = hold_rd_q;
    hold_data_d  = hold_data_q;
    rd_we_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    busy_d       = busy_q;

    if (pl_owns_port) begin
      rd_we_d   = 1'b1;
      rd_addr_d = pl_rd;
      rd_data_d = pl_wdata;
    end else if (hold_drain && (hold_rd_q != 5'd0)) begin
      rd_we_d   = 1'b1;
      rd_addr_d = hold_rd_q;
      rd_data_d = hold_data_q;
    end

    // A skid entry for x0 still drains. It just never raises rd_we.
    if (hold_drain) begin
      hold_valid_d      = 1'b0;
      busy_d[hold_rd_q] = 1'b0;
    end

    // md_xfer needs an empty skid register, so it never overlaps a drain.
    if (md_xfer) begin
      hold_valid_d = 1'b1;
      hold_rd_d    = md_rd;
      hold_data_d  = md_data;
    end

    // The set comes after the clear, so an issue wins over a drain to the
    // same register.
    if (iss_valid && (iss_rd != 5'd0)) begin
      busy_d[iss_rd] = 1'b1;
    end

    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_rd_q    <= 5'd0;
      hold_data_q  <= '0;
      rd_we_q      <= 1'b0;
      rd_addr_q    <= 5'd0;
      rd_data_q    <= '0;
      busy_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
      rd_we_q      <= rd_we_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      busy_q       <= busy_d;
    end
  end

  assign rd_we   = rd_we_q;
  assign rd_addr = rd_addr_q;
  assign rd_data = rd_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_rf_writeback.sv
// ---------------------------------------------------------------------------
// tb_rf_writeback
//
// Directed test-plan steps followed by a randomized phase. A reference model
// of the writeback rules predicts every output each cycle. Expected
// register-file writes also go through exp_q and are matched in order.
// ---------------------------------------------------------------------------
module tb_rf_writeback;

  logic        clk;
  logic        reset;
  logic        pl_valid;
  logic [4:0]  pl_rd;
  logic [31:0] pl_data;
  logic        pl_load;
  logic [2:0]  pl_funct3;
  logic [1:0]  pl_byte_off;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] busy;

  rf_writeback #(.XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .pl_valid    (pl_valid),
    .pl_rd       (pl_rd),
    .pl_data     (pl_data),
    .pl_load     (pl_load),
    .pl_funct3   (pl_funct3),
    .pl_byte_off (pl_byte_off),
    .md_valid    (md_valid),
    .md_rd       (md_rd),
    .md_data     (md_data),
    .md_ready    (md_ready),
    .iss_valid   (iss_valid),
    .iss_rd      (iss_rd),
    .rd_we       (rd_we),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy)
  );

  // -------------------------------------------------------------------------
  // Clock
  // -------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Counters and scoreboard
  // -------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  logic [36:0] exp_q[$];  // {rd, data} of expected writes, oldest first

  // Reference model state
  bit          m_hold_v;
  bit   [4:0]  m_hold_rd;
  bit   [31:0] m_hold_data;
  bit          m_we;
  bit   [4:0]  m_addr;
  bit   [31:0] m_data;
  bit   [31:0] m_busy;

  bit          watch_r3;
  bit          saw_r3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load result computed from the byte/halfword value, not from bit slicing.
  function automatic logic [31:0] load_ref(input logic [31:0] d, input logic ld,
                                           input logic [2:0] f3, input logic [1:0] off);
    int unsigned b;
    int unsigned h;
    if (!ld) return d;
    b = (d >> (8 * int'(off))) % 256;
    h = (d >> (16 * int'(off / 2))) % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? 32'(b - 256)   : 32'(b);
      3'b001:  return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return d;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Driver / checker: one clock cycle with the inputs already applied
  // -------------------------------------------------------------------------
  task automatic cycle();
    bit pl_wins;
    bit drains;
    logic [36:0] e;
    #1;
    chk("md_ready", {31'd0, md_ready}, {31'd0, (!m_hold_v && !reset)});

    if (reset) begin
      m_hold_v = 0; m_we = 0; m_addr = 0; m_data = 0; m_busy = 0;
      exp_q.delete();
    end else begin
      pl_wins = pl_valid && (pl_rd != 0);
      drains  = m_hold_v && !pl_wins;
      m_we    = 0;
      if (pl_wins) begin
        m_we = 1; m_addr = pl_rd;
        m_data = load_ref(pl_data, pl_load, pl_funct3, pl_byte_off);
      end else if (drains && m_hold_rd != 0) begin
        m_we = 1; m_addr = m_hold_rd; m_data = m_hold_data;
      end
      if (drains) begin
        m_busy[m_hold_rd] = 0;
        m_hold_v = 0;
      end else if (!m_hold_v && md_valid) begin
        m_hold_v = 1; m_hold_rd = md_rd; m_hold_data = md_data;
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
      m_busy[0] = 0;
      if (m_we) exp_q.push_back({m_addr, m_data});
    end

    @(posedge clk);
    #1;
    chk("rd_we",   {31'd0, rd_we},   {31'd0, m_we});
    chk("rd_addr", {27'd0, rd_addr}, {27'd0, m_addr});
    chk("rd_data", rd_data, m_data);
    chk("busy",    busy,    m_busy);
    if (rd_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("write_expected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("write_order", {27'd0, rd_addr} ^ rd_data, {27'd0, e[36:32]} ^ e[31:0]);
      end
      if (watch_r3 && rd_addr == 5'd3) saw_r3 = 1;
    end
  endtask

  task automatic idle_inputs();
    pl_valid = 0; pl_rd = 0; pl_data = 0; pl_load = 0; pl_funct3 = 0; pl_byte_off = 0;
    md_valid = 0; md_rd = 0; md_data = 0; iss_valid = 0; iss_rd = 0;
  endtask

  task automatic drive_pl(input logic [4:0] rd, input logic [31:0] d, input logic ld,
                          input logic [2:0] f3, input logic [1:0] off);
    pl_valid = 1; pl_rd = rd; pl_data = d; pl_load = ld; pl_funct3 = f3; pl_byte_off = off;
  endtask

  task automatic drive_md(input logic [4:0] rd, input logic [31:0] d);
    md_valid = 1; md_rd = rd; md_data = d;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic [31:0] ld_word;
  logic [2:0]  ld_f3  [5];
  logic [1:0]  ld_off [5];
  logic [31:0] ld_exp [5];

  initial begin
    ld_word = 32'h80F1_7F02;
    ld_f3[0] = 3'b000; ld_off[0] = 2'd3; ld_exp[0] = 32'hFFFF_FF80;
    ld_f3[1] = 3'b100; ld_off[1] = 2'd1; ld_exp[1] = 32'h0000_007F;
    ld_f3[2] = 3'b001; ld_off[2] = 2'd2; ld_exp[2] = 32'hFFFF_80F1;
    ld_f3[3] = 3'b101; ld_off[3] = 2'd0; ld_exp[3] = 32'h0000_7F02;
    ld_f3[4] = 3'b010; ld_off[4] = 2'd1; ld_exp[4] = 32'h80F1_7F02;
    watch_r3 = 0;
    saw_r3   = 0;

    // Reset
    idle_inputs();
    reset = 1;
    cycle();
    cycle();
    reset = 0;
    chk("reset_we",   {31'd0, rd_we}, 32'd0);
    chk("reset_busy", busy, 32'd0);
    cycle();  // first cycle after reset: md_ready must be 1

    // Load extension
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      drive_pl(5'd5, ld_word, 1'b1, ld_f3[i], ld_off[i]);
      cycle();
      chk("load_data", rd_data, ld_exp[i]);
      chk("load_addr", {27'd0, rd_addr}, 32'd5);
    end

    // x0 suppression: pl_rd = 0 lets the pending skid entry drain
    idle_inputs();
    drive_md(5'd9, 32'h0000_1234);
    cycle();
    idle_inputs();
    drive_pl(5'd0, 32'hAAAA_5555, 1'b0, 3'b010, 2'd0);
    cycle();
    chk("x0_we",   {31'd0, rd_we}, 32'd1);
    chk("x0_addr", {27'd0, rd_addr}, 32'd9);
    chk("x0_data", rd_data, 32'h0000_1234);

    // Contention: 4 pipeline writes, MUL/DIV result for x7 lands 5th
    idle_inputs();
    cycle();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      drive_pl(5'(i + 1), $urandom, 1'b0, 3'b010, 2'd0);
      if (i == 0) drive_md(5'd7, 32'hDEAD_BEEF);
      cycle();
      chk("cont_pl_addr", {27'd0, rd_addr}, 32'(i + 1));
      if (i > 0) chk("cont_md_ready_low", {31'd0, md_ready}, 32'd0);
    end
    idle_inputs();
    cycle();
    chk("cont_md_addr", {27'd0, rd_addr}, 32'd7);
    chk("cont_md_data", rd_data, 32'hDEAD_BEEF);
    idle_inputs();
    cycle();  // md_ready high again

    // Scoreboard
    idle_inputs();
    iss_valid = 1; iss_rd = 5'd12;
    cycle();
    chk("sb_set", {31'd0, busy[12]}, 32'd1);
    idle_inputs();
    drive_md(5'd12, 32'h0BAD_F00D);
    cycle();
    idle_inputs();
    cycle();
    chk("sb_clear", {31'd0, busy[12]}, 32'd0);
    chk("sb_clear_we", {31'd0, rd_we}, 32'd1);
    idle_inputs();
    drive_md(5'd12, 32'h1111_2222);
    iss_valid = 1; iss_rd = 5'd12;
    cycle();
    idle_inputs();
    iss_valid = 1; iss_rd = 5'd12;  // issue and drain of x12 together
    cycle();
    chk("sb_set_wins", {31'd0, busy[12]}, 32'd1);
    idle_inputs();
    iss_valid = 1; iss_rd = 5'd0;
    cycle();
    chk("sb_x0", {31'd0, busy[0]}, 32'd0);

    // Reset mid-operation: x3 parked in the skid register, then reset
    idle_inputs();
    iss_valid = 1; iss_rd = 5'd3;
    drive_md(5'd3, 32'h3333_3333);
    cycle();
    idle_inputs();
    drive_pl(5'd5, 32'h5555_0000, 1'b0, 3'b010, 2'd0);
    cycle();
    chk("rst_busy3", {31'd0, busy[3]}, 32'd1);
    watch_r3 = 1;
    idle_inputs();
    reset = 1;
    cycle();
    reset = 0;
    chk("rst_busy_clr", busy, 32'd0);
    chk("rst_we", {31'd0, rd_we}, 32'd0);
    for (int i = 0; i < 4; i++) cycle();
    watch_r3 = 0;
    chk("rst_no_r3_write", {31'd0, saw_r3}, 32'd0);

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      reset = ($urandom_range(0, 60) == 0);
      pl_valid    = ($urandom_range(0, 2) != 0);
      pl_rd       = 5'($urandom_range(0, 7));
      pl_data     = $urandom;
      pl_load     = $urandom_range(0, 1);
      pl_funct3   = 3'($urandom_range(0, 7));
      pl_byte_off = 2'($urandom_range(0, 3));
      md_valid    = $urandom_range(0, 1);
      md_rd       = 5'($urandom_range(0, 7));
      md_data     = $urandom;
      iss_valid   = $urandom_range(0, 1);
      iss_rd      = 5'($urandom_range(0, 7));
      cycle();
    end
    reset = 0;
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
